// File: rtl/fpnew_pkg_snax.sv
// ---------------------------------------------------------------------------
// fpnew_pkg_snax
// Purpose : Shared FPU definitions used by the rounding arbiter slice.
//           Provides the IEEE-754 rounding-mode encoding (roundmode_e).
// Ports   : none (package)
// ---------------------------------------------------------------------------
package fpnew_pkg_snax;

  // Encodings above RMM are not legal rounding decisions for the datapath.
  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

endpackage : fpnew_pkg_snax

// File: rtl/fpnew_rounding_snax.sv
// ---------------------------------------------------------------------------
// fpnew_rounding_snax
// Purpose : Purely combinational rounding of an unsigned magnitude using the
//           round/sticky bits and the selected rounding mode. The rounded
//           magnitude wraps to zero on overflow; no carry-out is produced.
// Ports   :
//   abs_value_i             unrounded absolute value
//   sign_i                  operand sign
//   round_sticky_bits_i     {R,S}
//   rnd_mode_i              rounding mode
//   effective_subtraction_i operation was an effective subtraction
//   abs_rounded_o           rounded absolute value
//   sign_o                  result sign (zero-sign rule applied)
//   exact_zero_o            result is an exact zero
// ---------------------------------------------------------------------------
module fpnew_rounding_snax
  import fpnew_pkg_snax::*;
#(
  parameter int unsigned AbsWidth = 32
) (
  input  logic [AbsWidth-1:0] abs_value_i,
  input  logic                sign_i,
  input  logic [1:0]          round_sticky_bits_i,
  input  roundmode_e          rnd_mode_i,
  input  logic                effective_subtraction_i,
  output logic [AbsWidth-1:0] abs_rounded_o,
  output logic                sign_o,
  output logic                exact_zero_o
);

  logic round_up;

  // Round-up decision per mode; illegal modes yield an unknown decision.
  always_comb begin
    round_up = 1'b0;
    unique case (rnd_mode_i)
      RNE: begin
        unique case (round_sticky_bits_i)
          2'b00, 2'b01: round_up = 1'b0;
          2'b10:        round_up = abs_value_i[0];
          2'b11:        round_up = 1'b1;
          default:      round_up = 1'bx;
        endcase
      end
      RTZ:     round_up = 1'b0;
      RDN:     round_up = (|round_sticky_bits_i) ? sign_i : 1'b0;
      RUP:     round_up = (|round_sticky_bits_i) ? ~sign_i : 1'b0;
      RMM:     round_up = round_sticky_bits_i[1];
      default: round_up = 1'bx;
    endcase
  end

  assign abs_rounded_o = abs_value_i + AbsWidth'(round_up);

  assign exact_zero_o = (abs_value_i == '0) && (round_sticky_bits_i == 2'b00);

  // An exact zero from an effective subtraction is -0 only when rounding down.
  assign sign_o = (exact_zero_o && effective_subtraction_i) ? (rnd_mode_i == RDN) : sign_i;

endmodule : fpnew_rounding_snax

// File: rtl/fpnew_rr_arbiter_snax.sv
// ---------------------------------------------------------------------------
// fpnew_rr_arbiter_snax
// Purpose : NumReq-wide round-robin arbiter. The search starts at the stored
//           pointer; the pointer moves to (winner + 1) mod NumReq only when a
//           grant is issued, which the parent treats as an accepted transfer.
// Ports   :
//   clk_i    clock
//   rst_ni   synchronous active-low reset (pointer -> 0)
//   en_i     granting allowed this cycle
//   req_i    per-requester request
//   gnt_o    one-hot grant (zero when disabled or no request)
//   idx_o    index of the granted requester
//   valid_o  a grant was issued
// ---------------------------------------------------------------------------
module fpnew_rr_arbiter_snax #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned TagWidth = $clog2(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [NumReq-1:0]   req_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [TagWidth-1:0] idx_o,
  output logic                valid_o
);

  logic [TagWidth-1:0] ptr_q, ptr_d;
  logic                found;
  int                  cand;

  // First requester at or after the pointer wins, wrapping modulo NumReq.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    ptr_d = ptr_q;
    cand  = 0;
    for (int off = 0; off < int'(NumReq); off++) begin
      cand = (int'(ptr_q) + off) % int'(NumReq);
      if (!found && en_i && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = TagWidth'(cand);
        ptr_d       = TagWidth'((cand + 1) % int'(NumReq));
      end
    end
  end

  assign valid_o = found;

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : fpnew_rr_arbiter_snax

// File: rtl/fpnew_rounding_arbiter_snax.sv
// ---------------------------------------------------------------------------
// fpnew_rounding_arbiter_snax
// Purpose : Shares one rounding datapath among NumReq requesters with a
//           round-robin grant and a single registered output stage
//           (latency 1, throughput 1/cycle, valid/ready handshakes).
// Config  : FPNEW_ROUND_ARB_MODECHK_EN -- when defined, illegal rounding modes
//           on an accepted request are replaced by RNE and flagged on a sticky
//           err_o, cleared by err_clear_i (set wins over clear).
// Ports   :
//   clk_i, rst_ni          clock, synchronous active-low reset
//   in_valid_i/in_ready_o  per-requester handshake
//   in_abs_value_i         per-requester unrounded magnitude
//   in_sign_i              per-requester sign
//   in_round_sticky_i      per-requester {R,S}
//   in_rnd_mode_i          per-requester rounding mode
//   in_eff_sub_i           per-requester effective-subtraction flag
//   out_valid_o/out_ready_i output handshake
//   out_abs_o, out_sign_o, out_exact_zero_o  rounded result
//   out_tag_o              originating requester index
//   err_o, err_clear_i     mode-check flag (FPNEW_ROUND_ARB_MODECHK_EN only)
// ---------------------------------------------------------------------------
module fpnew_rounding_arbiter_snax
  import fpnew_pkg_snax::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned AbsWidth = 32,
  localparam int unsigned TagWidth = $clog2(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumReq-1:0]                in_valid_i,
  output logic [NumReq-1:0]                in_ready_o,
  input  logic [NumReq-1:0][AbsWidth-1:0]  in_abs_value_i,
  input  logic [NumReq-1:0]                in_sign_i,
  input  logic [NumReq-1:0][1:0]           in_round_sticky_i,
  input  roundmode_e [NumReq-1:0]          in_rnd_mode_i,
  input  logic [NumReq-1:0]                in_eff_sub_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [AbsWidth-1:0]              out_abs_o,
  output logic                             out_sign_o,
  output logic                             out_exact_zero_o,
`ifdef FPNEW_ROUND_ARB_MODECHK_EN
  output logic                             err_o,
  input  logic                             err_clear_i,
`endif
  output logic [TagWidth-1:0]              out_tag_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e state_q, state_d;

  logic                stage_free;
  logic [NumReq-1:0]   gnt;
  logic [TagWidth-1:0] gnt_idx;
  logic                accept;

  logic [AbsWidth-1:0] sel_abs;
  logic                sel_sign;
  logic [1:0]          sel_rs;
  roundmode_e          sel_mode;
  roundmode_e          eff_mode;
  logic                sel_eff_sub;

  logic [AbsWidth-1:0] rnd_abs;
  logic                rnd_sign;
  logic                rnd_zero;

  logic [AbsWidth-1:0] abs_q;
  logic                sign_q;
  logic                zero_q;
  logic [TagWidth-1:0] tag_q;

  // The register can take new data when empty or when it is drained now.
  assign stage_free = (state_q == EMPTY) || out_ready_i;

  fpnew_rr_arbiter_snax #(
    .NumReq   (NumReq),
    .TagWidth (TagWidth)
  ) i_arbiter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (stage_free && rst_ni),
    .req_i   (in_valid_i),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (accept)
  );

  // Grants are only issued to valid requesters, so ready doubles as accept.
  assign in_ready_o = gnt;

  // One-hot mux of the granted requester's operands into the shared datapath.
  always_comb begin
    sel_abs     = '0;
    sel_sign    = 1'b0;
    sel_rs      = 2'b00;
    sel_mode    = RNE;
    sel_eff_sub = 1'b0;
    for (int i = 0; i < int'(NumReq); i++) begin
      if (gnt[i]) begin
        sel_abs     = in_abs_value_i[i];
        sel_sign    = in_sign_i[i];
        sel_rs      = in_round_sticky_i[i];
        sel_mode    = in_rnd_mode_i[i];
        sel_eff_sub = in_eff_sub_i[i];
      end
    end
  end

`ifdef FPNEW_ROUND_ARB_MODECHK_EN
  logic illegal_mode;
  logic err_q;

  assign illegal_mode = accept && (sel_mode > RMM);
  assign eff_mode     = (sel_mode > RMM) ? RNE : sel_mode;
  assign err_o        = err_q;

  // Sticky error flag; a new illegal request overrides a clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (illegal_mode) begin
      err_q <= 1'b1;
    end else if (err_clear_i) begin
      err_q <= 1'b0;
    end
  end
`else
  assign eff_mode = sel_mode;
`endif

  fpnew_rounding_snax #(
    .AbsWidth (AbsWidth)
  ) i_rounding (
    .abs_value_i             (sel_abs),
    .sign_i                  (sel_sign),
    .round_sticky_bits_i     (sel_rs),
    .rnd_mode_i              (eff_mode),
    .effective_subtraction_i (sel_eff_sub),
    .abs_rounded_o           (rnd_abs),
    .sign_o                  (rnd_sign),
    .exact_zero_o            (rnd_zero)
  );

  // Output FSM next state: accept always fills, a lone handshake drains.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (out_ready_i && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Output FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Result register; loads only on accept, so it holds under backpressure.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      abs_q  <= '0;
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      tag_q  <= '0;
    end else if (accept) begin
      abs_q  <= rnd_abs;
      sign_q <= rnd_sign;
      zero_q <= rnd_zero;
      tag_q  <= gnt_idx;
    end
  end

  assign out_valid_o      = (state_q == FULL);
  assign out_abs_o        = abs_q;
  assign out_sign_o       = sign_q;
  assign out_exact_zero_o = zero_q;
  assign out_tag_o        = tag_q;

endmodule : fpnew_rounding_arbiter_snax

// File: doc/fpnew_rounding_arbiter_snax.md
FPNEW_ROUNDING_ARBITER_SNAX -- requirements
Module: fpnew_rounding_arbiter_snax

Interface
REQ-001 SHALL have parameter NumReq, default 4, meaning number of requesters sharing the rounding unit (legal range 2..16).
REQ-002 SHALL have parameter AbsWidth, default 32, meaning width of the absolute value without sign bit (minimum 2).
REQ-003 SHALL derive TagWidth = $clog2(NumReq) as a localparam.
REQ-004 SHALL use one clock and a synchronous, active-low reset:
  clk_i  input  1  clock, all state on rising edge
  rst_ni  input  1  synchronous active-low reset
  in_valid_i  input  NumReq  per-requester request valid
  in_ready_o  output  NumReq  per-requester accept
  in_abs_value_i  input  NumReq x AbsWidth  unrounded absolute value
  in_sign_i  input  NumReq  operand sign
  in_round_sticky_i  input  NumReq x 2  round/sticky bits {R,S}
  in_rnd_mode_i  input  NumReq x roundmode_e  rounding mode
  in_eff_sub_i  input  NumReq  effective subtraction flag
  out_valid_o  output  1  result valid
  out_ready_i  input  1  consumer accept
  out_abs_o  output  AbsWidth  rounded absolute value
  out_sign_o  output  1  result sign
  out_exact_zero_o  output  1  exact-zero flag
  out_tag_o  output  TagWidth  index of the originating requester
  err_o  output  1  sticky illegal-mode flag (FPNEW_ROUND_ARB_MODECHK_EN only)
  err_clear_i  input  1  clears err_o (FPNEW_ROUND_ARB_MODECHK_EN only)

Function
REQ-005 SHALL share one combinational rounding datapath (RNE/RTZ/RDN/RUP/RMM, increment on round-up, zero-sign rule) among all requesters, followed by one output register.
REQ-006 SHALL implement a two-state output FSM: EMPTY (out_valid_o=0) and FULL (out_valid_o=1).
REQ-007 SHALL consider the stage free when the FSM is EMPTY, or when it is FULL and out_ready_i=1 in the same cycle.
REQ-008 SHALL grant at most one requester per cycle, and only when the stage is free; in_ready_o[i]=1 iff the stage is free and i is granted.
REQ-009 SHALL select the grant round-robin: search starts at (last accepted index + 1) mod NumReq; after reset the search starts at index 0.
REQ-010 SHALL advance the round-robin pointer only on an accepted transfer (in_valid_i[i] & in_ready_o[i]).
REQ-011 SHALL NOT make the grant depend on out_ready_i other than through the stage-free term; in_ready_o SHALL NOT depend on in_valid_i of the same requester beyond grant selection.
REQ-012 SHALL register the rounded result and the grant index into out_* one cycle after acceptance (latency 1, throughput 1 per cycle).
REQ-013 SHALL hold out_* stable while out_valid_o=1 and out_ready_i=0.
REQ-014 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on output handshake without accept; FULL->FULL with new data on simultaneous handshake and accept.
REQ-015 SHALL round an all-ones abs value with round-up to zero (wrap-around), carrying no extra bit.
REQ-016 SHALL, when no requester is valid, grant nobody and leave the pointer unchanged.

Reset
REQ-017 SHALL, on rst_ni=0 at a clock edge: FSM=EMPTY, out_valid_o=0, out_abs_o=0, out_sign_o=0, out_exact_zero_o=0, out_tag_o=0, pointer=0, err_o=0.
REQ-018 SHALL drive in_ready_o=0 for all requesters while rst_ni=0; a result held during mid-operation reset SHALL be discarded.

Configuration
REQ-019 SHALL, with FPNEW_ROUND_ARB_MODECHK_EN defined, substitute RNE for any rnd_mode outside RNE..RMM on an accepted request and set err_o on the following edge; err_o stays 1 until err_clear_i=1 (set takes priority over clear in the same cycle).
REQ-020 SHALL, without FPNEW_ROUND_ARB_MODECHK_EN, omit err_o and err_clear_i, and propagate X rounding decisions for illegal modes.

Structure
REQ-021 SHALL take roundmode_e and its encodings from package fpnew_pkg_snax; no new package types.
REQ-022 SHALL instantiate fpnew_rounding_snax as the shared datapath and a sub-module fpnew_rr_arbiter_snax (NumReq-wide round-robin grant with pointer).

Verification
REQ-023 Single request: req0 abs=0x5 RS=10 RNE sign=0, out_ready=1 -> next cycle out_valid=1, abs=0x6, tag=0.
REQ-024 All four valid continuously, out_ready=1 -> tags 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-025 Backpressure: out_ready=0 for 3 cycles while FULL -> out_* constant, all in_ready=0, no pointer change.
REQ-026 Zero sign: abs=0, RS=00, eff_sub=1, RDN, sign=0 -> out_sign=1, exact_zero=1; same with RNE -> out_sign=0.
REQ-027 Reset while FULL -> next cycle out_valid=0, pointer=0; requesters 0 and 2 valid -> req0 granted first.
REQ-028 With FPNEW_ROUND_ARB_MODECHK_EN: rnd_mode=3'b111, abs=0x3, RS=10 -> abs=0x4 (RNE), err_o=1 until err_clear_i pulse.
